// File: rtl/salamander_nvram_upload.sv
// NVRAM upload engine: requests an HPS upload session, then serves byte reads from NVRAM.
// Optional trailing checksum byte at address DEPTH is enabled by SALAMANDER_UPLOAD_CKSUM_EN.
module salamander_nvram_upload #(
    parameter int          ADDR_W       = 11,
    parameter int          MEM_LAT      = 2,
    parameter logic [15:0] UPLOAD_INDEX = 16'h0004,
    parameter int          REQ_TIMEOUT  = 65535
) (
    input  logic              i_EMU_MCLK,
    input  logic              i_EMU_SOFTRST,
    input  logic              i_SAVE_REQ,
    output logic              o_IOCTL_UPLOAD_REQ,
    input  logic              ioctl_upload,
    input  logic [15:0]       ioctl_index,
    input  logic              ioctl_rd,
    input  logic [26:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] o_MEM_ADDR,
    output logic              o_MEM_RD,
    input  logic [7:0]        i_MEM_DATA,
    output logic              o_BUSY,
    output logic              o_DONE,
    output logic              o_TIMEOUT
`ifdef SALAMANDER_UPLOAD_CKSUM_EN
    ,
    output logic [7:0]        o_CKSUM
`endif
);

    localparam int          DEPTH        = 1 << ADDR_W;
    localparam logic [26:0] DEPTH_ADDR   = 27'(DEPTH);
    localparam logic [15:0] TIMEOUT_LAST = 16'(REQ_TIMEOUT - 1);
    localparam logic [2:0]  LAT_LAST     = 3'(MEM_LAT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVE,
        ST_FETCH,
        ST_FINISH
    } state_t;

    state_t            state_reg;
    logic [15:0]       tmo_cnt_reg;
    logic [2:0]        lat_cnt_reg;
    logic              upload_req_reg;
    logic [7:0]        din_reg;
    logic              wait_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              mem_rd_reg;
    logic              done_reg;
    logic              timeout_reg;
`ifdef SALAMANDER_UPLOAD_CKSUM_EN
    logic [7:0]        sum_reg;
`endif

    logic in_range;
    logic index_match;

    assign in_range    = (ioctl_addr < DEPTH_ADDR);
    assign index_match = ioctl_upload && (ioctl_index == UPLOAD_INDEX);

    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_SOFTRST) begin
            state_reg      <= ST_IDLE;
            tmo_cnt_reg    <= '0;
            lat_cnt_reg    <= '0;
            upload_req_reg <= 1'b0;
            din_reg        <= 8'hFF;
            wait_reg       <= 1'b0;
            mem_addr_reg   <= '0;
            mem_rd_reg     <= 1'b0;
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
`ifdef SALAMANDER_UPLOAD_CKSUM_EN
            sum_reg        <= 8'h00;
`endif
        end else begin
            mem_rd_reg <= 1'b0;
            done_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // A session cannot begin while the HPS is still mid-transfer.
                    if (i_SAVE_REQ && !ioctl_upload) begin
                        state_reg      <= ST_REQ;
                        upload_req_reg <= 1'b1;
                        timeout_reg    <= 1'b0;
                        tmo_cnt_reg    <= '0;
`ifdef SALAMANDER_UPLOAD_CKSUM_EN
                        sum_reg        <= 8'h00;
`endif
                    end
                end
                ST_REQ: begin
                    if (index_match) begin
                        state_reg      <= ST_SERVE;
                        upload_req_reg <= 1'b0;
                    end else if (tmo_cnt_reg >= TIMEOUT_LAST) begin
                        state_reg      <= ST_IDLE;
                        upload_req_reg <= 1'b0;
                        timeout_reg    <= 1'b1;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
                    end
                end
                ST_SERVE: begin
                    if (!ioctl_upload) begin
                        state_reg <= ST_FINISH;
                    end else if (ioctl_rd) begin
                        if (in_range) begin
                            mem_addr_reg <= ioctl_addr[ADDR_W-1:0];
                            mem_rd_reg   <= 1'b1;
                            wait_reg     <= 1'b1;
                            lat_cnt_reg  <= '0;
                            state_reg    <= ST_FETCH;
`ifdef SALAMANDER_UPLOAD_CKSUM_EN
                        end else if (ioctl_addr == DEPTH_ADDR) begin
                            din_reg <= ~sum_reg + 8'd1;
`endif
                        end else begin
                            din_reg <= 8'hFF;
                        end
                    end
                end
                ST_FETCH: begin
                    // Reads arriving here are dropped; only upload loss or data arrival matter.
                    if (!ioctl_upload) begin
                        wait_reg  <= 1'b0;
                        state_reg <= ST_FINISH;
                    end else if (lat_cnt_reg == LAT_LAST) begin
                        din_reg   <= i_MEM_DATA;
                        wait_reg  <= 1'b0;
                        state_reg <= ST_SERVE;
`ifdef SALAMANDER_UPLOAD_CKSUM_EN
                        sum_reg   <= sum_reg + i_MEM_DATA;
`endif
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + 3'd1;
                    end
                end
                ST_FINISH: begin
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_IOCTL_UPLOAD_REQ = upload_req_reg;
    assign ioctl_din          = din_reg;
    assign ioctl_wait         = wait_reg;
    assign o_MEM_ADDR         = mem_addr_reg;
    assign o_MEM_RD           = mem_rd_reg;
    assign o_BUSY             = (state_reg != ST_IDLE);
    assign o_DONE             = done_reg;
    assign o_TIMEOUT          = timeout_reg;
`ifdef SALAMANDER_UPLOAD_CKSUM_EN
    assign o_CKSUM            = sum_reg;
`endif

endmodule

// File: tb/tb_salamander_nvram_upload.sv
// Self-checking bench for salamander_nvram_upload: table vectors, random reads against a
// behavioural byte model, and hand sequences for timeout, abort and reset corners.
module tb_salamander_nvram_upload;

    localparam int ADDR_W  = 11;
    localparam int MEM_LAT = 2;
    localparam int DEPTH   = 2048;

    logic              clk;
    logic              srst;
    logic              i_SAVE_REQ;
    logic              o_IOCTL_UPLOAD_REQ;
    logic              ioctl_upload;
    logic [15:0]       ioctl_index;
    logic              ioctl_rd;
    logic [26:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic [ADDR_W-1:0] o_MEM_ADDR;
    logic              o_MEM_RD;
    logic [7:0]        i_MEM_DATA;
    logic              o_BUSY;
    logic              o_DONE;
    logic              o_TIMEOUT;
`ifdef SALAMANDER_UPLOAD_CKSUM_EN
    logic [7:0]        o_CKSUM;
`endif

    salamander_nvram_upload #(
        .ADDR_W      (ADDR_W),
        .MEM_LAT     (MEM_LAT),
        .UPLOAD_INDEX(16'h0004),
        .REQ_TIMEOUT (65535)
    ) dut (
        .i_EMU_MCLK        (clk),
        .i_EMU_SOFTRST     (srst),
        .i_SAVE_REQ        (i_SAVE_REQ),
        .o_IOCTL_UPLOAD_REQ(o_IOCTL_UPLOAD_REQ),
        .ioctl_upload      (ioctl_upload),
        .ioctl_index       (ioctl_index),
        .ioctl_rd          (ioctl_rd),
        .ioctl_addr        (ioctl_addr),
        .ioctl_din         (ioctl_din),
        .ioctl_wait        (ioctl_wait),
        .o_MEM_ADDR        (o_MEM_ADDR),
        .o_MEM_RD          (o_MEM_RD),
        .i_MEM_DATA        (i_MEM_DATA),
        .o_BUSY            (o_BUSY),
        .o_DONE            (o_DONE),
        .o_TIMEOUT         (o_TIMEOUT)
`ifdef SALAMANDER_UPLOAD_CKSUM_EN
        ,
        .o_CKSUM           (o_CKSUM)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // NVRAM model: data is valid only in the cycle MEM_LAT cycles after the strobe, garbage otherwise.
    logic [7:0]        mem [DEPTH];
    int                mem_age = -1;
    logic [ADDR_W-1:0] mem_pa = '0;
    always @(negedge clk) begin
        if (o_MEM_RD) begin
            mem_age = 0;
            mem_pa  = o_MEM_ADDR;
        end else if (mem_age >= 0 && mem_age < 1000) begin
            mem_age++;
        end
        if (mem_age == MEM_LAT) i_MEM_DATA = mem[mem_pa];
        else                    i_MEM_DATA = 8'($urandom);
    end

    // Behavioural view of what the HPS should receive for one read.
    logic [7:0] model_sum;
    function automatic logic [7:0] model_byte(input logic [26:0] a);
        if (a < 27'(DEPTH)) return mem[a[ADDR_W-1:0]];
`ifdef SALAMANDER_UPLOAD_CKSUM_EN
        if (a == 27'(DEPTH)) return 8'(8'd0 - model_sum);
`endif
        return 8'hFF;
    endfunction

    typedef struct {
        logic [26:0] addr;
        bit          second;
        logic [7:0]  exp_din;
        int          exp_wait;
        int          exp_rds;
    } vec_t;

    task automatic start_session(input bit wrong_idx, output int n);
        ioctl_upload = 1'b0;
        ioctl_index  = 16'h0004;
        i_SAVE_REQ   = 1'b1;
        @(negedge clk);
        i_SAVE_REQ = 1'b0;
        model_sum  = 8'h00;
        n = 0;
        for (int i = 1; i <= 14; i++) begin
            if (o_IOCTL_UPLOAD_REQ) n++;
            if (wrong_idx && i == 3) begin
                ioctl_upload = 1'b1;
                ioctl_index  = 16'h0003;
            end
            if (i == 10) begin
                ioctl_upload = 1'b1;
                ioctl_index  = 16'h0004;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        logic [7:0] din;
        int         wcyc;
        int         rds;
        bit         addr_ok;
        ioctl_addr = v.addr;
        ioctl_rd   = 1'b1;
        @(negedge clk);
        ioctl_rd = 1'b0;
        wcyc = 0;
        rds = 0;
        addr_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (o_MEM_RD) begin
                rds++;
                if (o_MEM_ADDR != v.addr[ADDR_W-1:0]) addr_ok = 1'b0;
            end
            if (!ioctl_wait) break;
            wcyc++;
            if (v.second && i == 0) begin
                ioctl_rd   = 1'b1;
                ioctl_addr = 27'($urandom_range(0, DEPTH - 1));
            end else begin
                ioctl_rd = 1'b0;
            end
            @(negedge clk);
        end
        ioctl_rd = 1'b0;
        din = ioctl_din;
        repeat (2) begin
            @(negedge clk);
            if (o_MEM_RD) rds++;
        end
        if (v.addr < 27'(DEPTH)) model_sum = model_sum + mem[v.addr[ADDR_W-1:0]];
        $display("%s addr=%0h din=%0h wait=%0d rds=%0d", tag, v.addr, din, wcyc, rds);
        check({tag, " din"}, 32'(din), 32'(v.exp_din));
        check({tag, " wait_cycles"}, 32'(wcyc), 32'(v.exp_wait));
        check({tag, " mem_rd_count"}, 32'(rds), 32'(v.exp_rds));
        check({tag, " mem_addr"}, 32'(addr_ok), 32'd1);
        check({tag, " din_hold"}, 32'(ioctl_din), 32'(v.exp_din));
    endtask

    task automatic end_session(input string tag);
        int d;
        d = 0;
        ioctl_upload = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (o_DONE) d++;
        end
        $display("%s done_pulses=%0d", tag, d);
        check({tag, " done_pulses"}, 32'(d), 32'd1);
        check({tag, " busy"}, 32'(o_BUSY), 32'd0);
        check({tag, " wait"}, 32'(ioctl_wait), 32'd0);
    endtask

    vec_t vecs [7];

    initial begin
        int   n;
        int   d;
        vec_t v;
        int   r;

        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        mem[5] = 8'hA5;
        mem[1] = 8'h01;
        mem[2] = 8'h02;

        vecs[0] = '{27'd5,          1'b0, 8'hA5,     MEM_LAT + 1, 1};
        vecs[1] = '{27'd0,          1'b0, mem[0],    MEM_LAT + 1, 1};
        vecs[2] = '{27'd2047,       1'b1, mem[2047], MEM_LAT + 1, 1};
        vecs[3] = '{27'd100,        1'b1, mem[100],  MEM_LAT + 1, 1};
        vecs[4] = '{27'd2049,       1'b0, 8'hFF,     0,           0};
        vecs[5] = '{27'h7FF_FFFF,   1'b0, 8'hFF,     0,           0};
`ifdef SALAMANDER_UPLOAD_CKSUM_EN
        vecs[6] = '{27'd3,          1'b0, mem[3],    MEM_LAT + 1, 1};
`else
        vecs[6] = '{27'd2048,       1'b0, 8'hFF,     0,           0};
`endif

        // Reset with a save request and read strobe that must both be discarded.
        srst = 1'b1;
        i_SAVE_REQ = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_index = 16'h0;
        ioctl_rd = 1'b1;
        ioctl_addr = 27'd5;
        model_sum = 8'h00;
        repeat (3) @(negedge clk);
        $display("reset state req=%0b din=%0h wait=%0b busy=%0b", o_IOCTL_UPLOAD_REQ, ioctl_din, ioctl_wait, o_BUSY);
        check("rst req", 32'(o_IOCTL_UPLOAD_REQ), 32'd0);
        check("rst din", 32'(ioctl_din), 32'hFF);
        check("rst wait", 32'(ioctl_wait), 32'd0);
        check("rst mem_rd", 32'(o_MEM_RD), 32'd0);
        check("rst mem_addr", 32'(o_MEM_ADDR), 32'd0);
        check("rst busy", 32'(o_BUSY), 32'd0);
        check("rst done", 32'(o_DONE), 32'd0);
        check("rst timeout", 32'(o_TIMEOUT), 32'd0);
        srst = 1'b0;
        i_SAVE_REQ = 1'b0;
        ioctl_rd = 1'b0;
        @(negedge clk);
        check("post_rst busy", 32'(o_BUSY), 32'd0);

        // No session may start while the HPS already has an upload open.
        ioctl_upload = 1'b1;
        ioctl_index = 16'h0004;
        i_SAVE_REQ = 1'b1;
        @(negedge clk);
        i_SAVE_REQ = 1'b0;
        @(negedge clk);
        $display("save during upload busy=%0b req=%0b", o_BUSY, o_IOCTL_UPLOAD_REQ);
        check("blocked busy", 32'(o_BUSY), 32'd0);
        check("blocked req", 32'(o_IOCTL_UPLOAD_REQ), 32'd0);
        ioctl_upload = 1'b0;
        @(negedge clk);

        // Session 1: table vectors then random reads.
        start_session(1'b0, n);
        $display("session1 req_cycles=%0d busy=%0b", n, o_BUSY);
        check("s1 req_cycles", 32'(n), 32'd10);
        check("s1 busy", 32'(o_BUSY), 32'd1);
        check("s1 req_low", 32'(o_IOCTL_UPLOAD_REQ), 32'd0);
        for (int i = 0; i < 7; i++) run_vec($sformatf("tbl%0d", i), vecs[i]);
        for (int i = 0; i < 30; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       v.addr = 27'($urandom_range(0, DEPTH - 1));
            else if (r == 7) v.addr = 27'(DEPTH);
            else if (r == 8) v.addr = 27'(DEPTH + int'($urandom_range(1, 5000)));
            else             v.addr = 27'($urandom) | 27'h400_0000;
            v.exp_din  = model_byte(v.addr);
            v.second   = (v.addr < 27'(DEPTH)) ? 1'($urandom_range(0, 1)) : 1'b0;
            v.exp_wait = (v.addr < 27'(DEPTH)) ? MEM_LAT + 1 : 0;
            v.exp_rds  = (v.addr < 27'(DEPTH)) ? 1 : 0;
            run_vec($sformatf("rnd%0d", i), v);
        end
        end_session("s1 end");

`ifdef SALAMANDER_UPLOAD_CKSUM_EN
        // Checksum byte closes the image so all bytes sum to zero.
        start_session(1'b0, n);
        check("ck req_cycles", 32'(n), 32'd10);
        run_vec("ck1", '{27'd1, 1'b0, 8'h01, MEM_LAT + 1, 1});
        run_vec("ck2", '{27'd2, 1'b0, 8'h02, MEM_LAT + 1, 1});
        check("ck running_sum", 32'(o_CKSUM), 32'h03);
        run_vec("ck_tail", '{27'd2048, 1'b0, 8'hFD, 0, 0});
        end_session("ck end");
`endif

        // Session 2: wrong index first, then upload drops mid-fetch.
        start_session(1'b1, n);
        $display("session2 req_cycles=%0d busy=%0b", n, o_BUSY);
        check("s2 req_cycles", 32'(n), 32'd10);
        check("s2 busy", 32'(o_BUSY), 32'd1);
        ioctl_addr = 27'd5;
        ioctl_rd = 1'b1;
        @(negedge clk);
        ioctl_rd = 1'b0;
        check("s2 wait_on", 32'(ioctl_wait), 32'd1);
        ioctl_upload = 1'b0;
        @(negedge clk);
        check("s2 wait_abort", 32'(ioctl_wait), 32'd0);
        d = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_DONE) d++;
        end
        $display("session2 abort done_pulses=%0d", d);
        check("s2 done_pulses", 32'(d), 32'd1);
        check("s2 busy_end", 32'(o_BUSY), 32'd0);

        // Session 3: reset lands during a fetch.
        start_session(1'b0, n);
        check("s3 req_cycles", 32'(n), 32'd10);
        ioctl_addr = 27'd7;
        ioctl_rd = 1'b1;
        @(negedge clk);
        ioctl_rd = 1'b0;
        check("s3 wait_on", 32'(ioctl_wait), 32'd1);
        srst = 1'b1;
        @(negedge clk);
        d = o_DONE ? 1 : 0;
        check("s3 wait_rst", 32'(ioctl_wait), 32'd0);
        check("s3 busy_rst", 32'(o_BUSY), 32'd0);
        srst = 1'b0;
        ioctl_upload = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (o_DONE) d++;
        end
        $display("session3 reset done_pulses=%0d", d);
        check("s3 done_pulses", 32'(d), 32'd0);

        // Session 4: HPS never answers.
        ioctl_upload = 1'b0;
        i_SAVE_REQ = 1'b1;
        @(negedge clk);
        i_SAVE_REQ = 1'b0;
        n = 0;
        for (int i = 0; i < 70000; i++) begin
            if (!o_IOCTL_UPLOAD_REQ) break;
            n++;
            @(negedge clk);
        end
        $display("session4 req_cycles=%0d timeout=%0b busy=%0b", n, o_TIMEOUT, o_BUSY);
        check("s4 req_cycles", 32'(n), 32'd65535);
        check("s4 timeout", 32'(o_TIMEOUT), 32'd1);
        check("s4 busy", 32'(o_BUSY), 32'd0);
        repeat (3) @(negedge clk);
        check("s4 timeout_sticky", 32'(o_TIMEOUT), 32'd1);
        i_SAVE_REQ = 1'b1;
        @(negedge clk);
        i_SAVE_REQ = 1'b0;
        $display("session5 start timeout=%0b req=%0b", o_TIMEOUT, o_IOCTL_UPLOAD_REQ);
        check("s5 timeout_clr", 32'(o_TIMEOUT), 32'd0);
        check("s5 req", 32'(o_IOCTL_UPLOAD_REQ), 32'd1);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        check("s5 rst_req", 32'(o_IOCTL_UPLOAD_REQ), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/salamander_nvram_upload.md
SALAMANDER_NVRAM_UPLOAD -- requirements
Module: salamander_nvram_upload

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDR_W, 11, NVRAM address width; DEPTH = 2^ADDR_W bytes.
- MEM_LAT, 2, cycles from o_MEM_RD to valid i_MEM_DATA (range 1..7).
- UPLOAD_INDEX, 16'h0004, ioctl_index value this block serves.
- REQ_TIMEOUT, 65535, cycles allowed for HPS to start the upload.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning); clock and reset first:
- i_EMU_MCLK, in, 1, sole clock; all logic on the rising edge.
- i_EMU_SOFTRST, in, 1, reset, synchronous active-high.
- i_SAVE_REQ, in, 1, one-cycle save request from OSD logic.
- o_IOCTL_UPLOAD_REQ, out, 1, request to hps_io ioctl_upload_req.
- ioctl_upload, in, 1, HPS upload session active.
- ioctl_index, in, 16, current transfer index.
- ioctl_rd, in, 1, one-cycle byte read strobe from HPS.
- ioctl_addr, in, 27, byte address qualified by ioctl_rd.
- ioctl_din, out, 8, byte returned to HPS.
- ioctl_wait, out, 1, stall to HPS while a fetch is pending.
- o_MEM_ADDR, out, ADDR_W, NVRAM read address.
- o_MEM_RD, out, 1, one-cycle NVRAM read strobe.
- i_MEM_DATA, in, 8, NVRAM read data.
- o_BUSY, out, 1, high in any state other than IDLE.
- o_DONE, out, 1, one-cycle pulse when a session ends normally.
- o_TIMEOUT, out, 1, sticky flag; set on request timeout, cleared by the next accepted i_SAVE_REQ.

Function
REQ-003 The FSM SHALL have the states IDLE, REQ, SERVE, FETCH and FINISH.
REQ-004 IDLE, i_SAVE_REQ=1 -> REQ: o_IOCTL_UPLOAD_REQ=1 on the next cycle, o_TIMEOUT cleared, timeout counter cleared.
REQ-005 REQ: o_IOCTL_UPLOAD_REQ stays high.
- On ioctl_upload=1 with ioctl_index==UPLOAD_INDEX: -> SERVE, request deasserted.
- When the counter reaches REQ_TIMEOUT: -> IDLE, o_TIMEOUT=1.
REQ-006 SERVE, ioctl_rd=1 with ioctl_addr<DEPTH:
- o_MEM_ADDR=ioctl_addr[ADDR_W-1:0] and o_MEM_RD=1 on the next cycle.
- ioctl_wait=1 on that same cycle; -> FETCH.
REQ-007 FETCH:
- Count MEM_LAT cycles after o_MEM_RD, then latch i_MEM_DATA into ioctl_din.
- Drop ioctl_wait in the same cycle as the latch; -> SERVE.
- Total ioctl_wait high time SHALL be exactly MEM_LAT+1 cycles.
REQ-008 SERVE, ioctl_rd=1 with ioctl_addr>=DEPTH (outside the REQ-019 case): ioctl_din=8'hFF on the next cycle, no wait, no memory read.
REQ-009 ioctl_rd arriving in FETCH SHALL be ignored; no second read is queued.
REQ-010 ioctl_din SHALL hold its last value between reads.
REQ-011 ioctl_upload falling in SERVE or FETCH:
- Abort any pending fetch; ioctl_wait=0 next cycle.
- -> FINISH, then o_DONE=1 for one cycle and -> IDLE.
REQ-012 i_SAVE_REQ outside IDLE SHALL be ignored.
REQ-013 A session SHALL NOT start (IDLE->REQ) while ioctl_upload=1.
REQ-014 ioctl_upload=1 with a non-matching index in REQ: remain in REQ and keep counting.
REQ-015 The timeout counter SHALL be 16 bits and saturate at REQ_TIMEOUT; no wrap.

Reset
REQ-016 While i_EMU_SOFTRST=1, on the clock edge: state=IDLE; all outputs 0 except ioctl_din=8'hFF; counters cleared.
REQ-017 Reset mid-session SHALL abort immediately.
- No o_DONE pulse.
- ioctl_wait and o_IOCTL_UPLOAD_REQ low the cycle after the reset edge.
REQ-018 i_SAVE_REQ and ioctl_rd during reset SHALL be discarded.

Configuration
REQ-019 Macro SALAMANDER_UPLOAD_CKSUM_EN:
- Defined: an 8-bit sum of every byte latched in FETCH during the current session, cleared on REQ entry. A read at ioctl_addr==DEPTH returns (~sum+1) on the next cycle, no wait, so all DEPTH+1 bytes sum to 8'h00. An optional output o_CKSUM[7:0] carries the running sum.
- Undefined: the address DEPTH returns 8'hFF per REQ-008; no sum logic and no o_CKSUM port.

Verification
REQ-020 SAVE_REQ pulse, HPS raises ioctl_upload/index 4 after 10 cycles -> request high for exactly 10 cycles, state SERVE.
REQ-021 With MEM_LAT=2 and mem[0x005]=8'hA5, rd at addr 5 -> o_MEM_RD with o_MEM_ADDR=5 the next cycle, ioctl_wait high 3 cycles, ioctl_din=8'hA5 when wait falls.
REQ-022 No HPS response -> after 65535 cycles o_TIMEOUT=1, state IDLE, request low; the next SAVE_REQ clears o_TIMEOUT.
REQ-023 rd at addr 2048 (ADDR_W=11, macro undefined) -> ioctl_din=8'hFF, ioctl_wait never high; a second rd during FETCH produces no extra o_MEM_RD.
REQ-024 With the macro defined, bytes 0x01,0x02 read, then rd at addr 2048 -> ioctl_din=8'hFD; ioctl_upload falls -> one o_DONE pulse.
REQ-025 Reset asserted in FETCH -> ioctl_wait=0 and o_BUSY=0 the next cycle, o_DONE never pulses.
